// File: rtl/game_sequencer_if.sv
// Drop-game sequencer bus: buttons, life flag and the
// action-block handshake grouped for the sequencer port.
interface game_sequencer_if;
  logic       start_i;
  logic       pause_i;
  logic       left_i;
  logic       right_i;
  logic       over_i;
  logic       d_act_i;
  logic       e_act_o;
  logic       left_o;
  logic       right_o;
  logic       act_reset_o;
  logic [1:0] state_o;
  logic [2:0] level_o;

  modport master (
    output start_i,
    output pause_i,
    output left_i,
    output right_i,
    output over_i,
    output d_act_i,
    input  e_act_o,
    input  left_o,
    input  right_o,
    input  act_reset_o,
    input  state_o,
    input  level_o
  );

  modport slave (
    input  start_i,
    input  pause_i,
    input  left_i,
    input  right_i,
    input  over_i,
    input  d_act_i,
    output e_act_o,
    output left_o,
    output right_o,
    output act_reset_o,
    output state_o,
    output level_o
  );
endinterface

// File: rtl/game_sequencer.sv
// Drop-game step sequencer: paces the action block, latches
// move requests and runs the IDLE/RUN/PAUSE/OVER game flow.
module game_sequencer #(
  parameter int unsigned     TW              = 24,
  parameter logic [TW-1:0]   BASE_PERIOD     = 24'd6000000,
  parameter logic [TW-1:0]   PERIOD_STEP     = 24'd500000,
  parameter logic [TW-1:0]   MIN_PERIOD      = 24'd1000000,
  parameter logic [7:0]      TICKS_PER_LEVEL = 8'd20,
  parameter logic [2:0]      MAX_LEVEL       = 3'd7
) (
  input  logic             clk_i,
  input  logic             reset_i,
  game_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  localparam int B_START = 3;
  localparam int B_PAUSE = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  localparam logic [TW-1:0] ONE =
    {{(TW-1){1'b0}}, 1'b1};

  // Clamp before subtracting so a large level never wraps.
  function automatic logic [TW-1:0] period_of(
    input logic [2:0] lvl
  );
    logic [TW+2:0] dec;
    logic [TW+2:0] room;
    dec  = {3'b000, PERIOD_STEP} * {{TW{1'b0}}, lvl};
    room = '0;
    if (BASE_PERIOD > MIN_PERIOD)
      room = {3'b000, BASE_PERIOD - MIN_PERIOD};
    if (dec >= room)
      period_of = MIN_PERIOD;
    else
      period_of = BASE_PERIOD - dec[TW-1:0];
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    sync3_q, sync3_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] period_q, period_d;
  logic          due_q, due_d;
  logic          busy_q, busy_d;
  logic          pend_l_q, pend_l_d;
  logic          pend_r_q, pend_r_d;
  logic [7:0]    step_q, step_d;
  logic [2:0]    level_q, level_d;
  logic          e_act_q, e_act_d;
  logic          left_q, left_d;
  logic          right_q, right_d;
  logic          act_rst_q, act_rst_d;

  logic [3:0]    btn_edge;
  logic          wrap;
  logic          fire;
  logic          restart;
  logic [7:0]    step_inc;

  // Two-flop synchroniser plus one delay flop for edge detect.
  always_comb begin
    sync1_d = {bus.start_i, bus.pause_i,
               bus.left_i, bus.right_i};
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  assign btn_edge = sync2_q & ~sync3_q;
  assign wrap     = (tick_q == period_q - ONE);
  assign fire     = due_q & ~busy_q;
  assign step_inc = step_q + 8'd1;

  // Game flow, step pacing, handshake and pending requests.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    period_d  = period_q;
    due_d     = due_q;
    busy_d    = busy_q;
    pend_l_d  = pend_l_q;
    pend_r_d  = pend_r_q;
    step_d    = step_q;
    level_d   = level_q;
    e_act_d   = 1'b0;
    left_d    = 1'b0;
    right_d   = 1'b0;
    act_rst_d = 1'b0;
    restart   = 1'b0;

    if (busy_q && bus.d_act_i)
      busy_d = 1'b0;

    unique case (state_q)
      S_IDLE: restart = btn_edge[B_START];
      S_RUN: begin
        if (bus.over_i) begin
          state_d = S_OVER;
        end else if (btn_edge[B_START]) begin
          restart = 1'b1;
        end else if (btn_edge[B_PAUSE]) begin
          state_d  = S_PAUSE;
          pend_l_d = 1'b0;
          pend_r_d = 1'b0;
        end else begin
          if (fire) begin
            e_act_d  = 1'b1;
            left_d   = pend_l_q & ~pend_r_q;
            right_d  = pend_r_q & ~pend_l_q;
            busy_d   = 1'b1;
            pend_l_d = 1'b0;
            pend_r_d = 1'b0;
            due_d    = 1'b0;
            if (step_inc >= TICKS_PER_LEVEL) begin
              step_d = '0;
              if (level_q != MAX_LEVEL)
                level_d = level_q + 3'd1;
            end else begin
              step_d = step_inc;
            end
          end
          // A level change lands on the count after this one.
          if (wrap) begin
            tick_d   = '0;
            due_d    = 1'b1;
            period_d = period_of(level_q);
          end else begin
            tick_d = tick_q + ONE;
          end
          if (btn_edge[B_LEFT])
            pend_l_d = 1'b1;
          if (btn_edge[B_RIGHT])
            pend_r_d = 1'b1;
        end
      end
      S_PAUSE: begin
        if (btn_edge[B_START])
          restart = 1'b1;
        else if (btn_edge[B_PAUSE])
          state_d = S_RUN;
      end
      S_OVER: restart = btn_edge[B_START];
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d   = S_RUN;
      act_rst_d = 1'b1;
      tick_d    = '0;
      period_d  = period_of(3'd0);
      due_d     = 1'b0;
      busy_d    = 1'b0;
      pend_l_d  = 1'b0;
      pend_r_d  = 1'b0;
      step_d    = '0;
      level_d   = '0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      tick_q    <= '0;
      period_q  <= period_of(3'd0);
      due_q     <= 1'b0;
      busy_q    <= 1'b0;
      pend_l_q  <= 1'b0;
      pend_r_q  <= 1'b0;
      step_q    <= '0;
      level_q   <= '0;
      e_act_q   <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      act_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      tick_q    <= tick_d;
      period_q  <= period_d;
      due_q     <= due_d;
      busy_q    <= busy_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      step_q    <= step_d;
      level_q   <= level_d;
      e_act_q   <= e_act_d;
      left_q    <= left_d;
      right_q   <= right_d;
      act_rst_q <= act_rst_d;
    end
  end

  assign bus.e_act_o     = e_act_q;
  assign bus.left_o      = left_q;
  assign bus.right_o     = right_q;
  assign bus.act_reset_o = act_rst_q;
  assign bus.state_o     = state_q;
  assign bus.level_o     = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: cycle model of the game rules
// plus directed scenarios with hand-derived timings.
module tb_game_sequencer;

  localparam logic [23:0] BASE = 24'd10;
  localparam logic [23:0] STEP = 24'd2;
  localparam logic [23:0] MINP = 24'd4;
  localparam logic [7:0]  TPL  = 8'd3;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  game_sequencer_if bus();

  game_sequencer #(
    .TW              (24),
    .BASE_PERIOD     (BASE),
    .PERIOD_STEP     (STEP),
    .MIN_PERIOD      (MINP),
    .TICKS_PER_LEVEL (TPL),
    .MAX_LEVEL       (3'd7)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_chk   = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_pulse = 0;
  int n_left  = 0;
  int n_right = 0;
  int n_ar    = 0;
  bit chk_on  = 1'b0;

  // ---------------- behavioural model ----------------
  // states: 0 idle, 1 run, 2 pause, 3 over
  int       m_state = 0;
  int       m_rem   = 10;
  int       m_steps = 0;
  int       m_level = 0;
  bit       m_due   = 0;
  bit       m_busy  = 0;
  bit       m_pl    = 0;
  bit       m_pr    = 0;
  bit       x_e = 0, x_l = 0, x_r = 0, x_ar = 0;
  bit [3:0] past [3];

  function automatic int per(input int lvl);
    int p;
    p = int'(BASE) - lvl * int'(STEP);
    if (p < int'(MINP)) p = int'(MINP);
    return p;
  endfunction

  task automatic m_restart();
    x_ar    = 1;
    m_state = 1;
    m_rem   = per(0);
    m_steps = 0;
    m_level = 0;
    m_due   = 0;
    m_busy  = 0;
    m_pl    = 0;
    m_pr    = 0;
  endtask

  task automatic m_reset();
    m_state = 0;
    m_rem   = per(0);
    m_steps = 0;
    m_level = 0;
    m_due   = 0;
    m_busy  = 0;
    m_pl    = 0;
    m_pr    = 0;
    x_e = 0; x_l = 0; x_r = 0; x_ar = 0;
    for (int i = 0; i < 3; i++) past[i] = '0;
  endtask

  task automatic m_step();
    bit [3:0] ed;
    bit       fire;
    int       lvl0;
    // a press is seen two samples late, once per rise
    ed = past[1] & ~past[2];
    past[2] = past[1];
    past[1] = past[0];
    past[0] = {bus.start_i, bus.pause_i,
               bus.left_i, bus.right_i};
    x_e = 0; x_l = 0; x_r = 0; x_ar = 0;
    fire = m_due && !m_busy;
    if (m_busy && bus.d_act_i) m_busy = 0;
    case (m_state)
      0: if (ed[3]) m_restart();
      1: begin
        if (bus.over_i) m_state = 3;
        else if (ed[3]) m_restart();
        else if (ed[2]) begin
          m_state = 2; m_pl = 0; m_pr = 0;
        end else begin
          lvl0 = m_level;
          if (fire) begin
            x_e = 1;
            x_l = m_pl && !m_pr;
            x_r = m_pr && !m_pl;
            m_busy = 1; m_pl = 0; m_pr = 0; m_due = 0;
            m_steps++;
            if (m_steps == int'(TPL)) begin
              m_steps = 0;
              if (m_level < 7) m_level++;
            end
          end
          if (m_rem == 1) begin
            m_due = 1;
            m_rem = per(lvl0);
          end else begin
            m_rem--;
          end
          if (ed[1]) m_pl = 1;
          if (ed[0]) m_pr = 1;
        end
      end
      2: begin
        if (ed[3]) m_restart();
        else if (ed[2]) m_state = 1;
      end
      default: if (ed[3]) m_restart();
    endcase
  endtask

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) m_reset();
    else m_step();
  end

  always @(posedge clk_i) cyc++;

  // ---------------- checking ----------------
  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("e_act_o", 32'(bus.e_act_o), 32'(x_e));
      chk("left_o", 32'(bus.left_o), 32'(x_l));
      chk("right_o", 32'(bus.right_o), 32'(x_r));
      chk("act_reset_o", 32'(bus.act_reset_o), 32'(x_ar));
      chk("state_o", 32'(bus.state_o), m_state);
      chk("level_o", 32'(bus.level_o), m_level);
      if (bus.e_act_o === 1'b1) n_pulse++;
      if (bus.e_act_o === 1'b1 && bus.left_o === 1'b1)
        n_left++;
      if (bus.e_act_o === 1'b1 && bus.right_o === 1'b1)
        n_right++;
      if (bus.act_reset_o === 1'b1) n_ar++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nstep();
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      3: bus.start_i = v;
      2: bus.pause_i = v;
      1: bus.left_i  = v;
      default: bus.right_i = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    repeat (hold) nstep();
    set_btn(b, 1'b0);
  endtask

  task automatic wait_pulse(input int budget);
    bit got;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      nstep();
      if (bus.e_act_o === 1'b1) got = 1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL pulse_timeout: none in %0d cycles",
               budget);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.e_act_o, bus.left_o, bus.right_o,
                bus.act_reset_o, bus.state_o,
                bus.level_o});
  endfunction

  int t_p [1:24];
  int lv  [1:24];
  int gap_tab [23] = '{10, 10, 10, 8, 8, 8, 6, 6, 6,
                       4, 4, 4, 4, 4, 4, 4, 4, 4,
                       4, 4, 4, 4, 4};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0, ar0, t_run, t_pulse;
    logic [4:0] pat;

    bus.start_i = 0; bus.pause_i = 0;
    bus.left_i  = 0; bus.right_i = 0;
    bus.over_i  = 0; bus.d_act_i = 1;

    // reset state
    repeat (3) nstep();
    chk_on = 1'b1;
    chk("reset_outputs", all_outs(), 0);
    reset_i = 1'b0;
    repeat (2) nstep();
    chk("idle_state", 32'(bus.state_o), 0);

    // 1: start, pacing and level-driven period shrink
    ar0 = n_ar;
    press(3, 4);
    repeat (3) nstep();
    chk("start_ar_count", n_ar - ar0, 1);
    chk("start_state_run", 32'(bus.state_o), 1);
    for (int k = 1; k <= 24; k++) begin
      wait_pulse(40);
      t_p[k] = cyc;
      lv[k]  = int'(bus.level_o);
    end
    for (int k = 0; k < 23; k++)
      chk($sformatf("gap%0d", k + 1),
          t_p[k + 2] - t_p[k + 1], gap_tab[k]);
    chk("level_at_3", lv[3], 1);
    chk("level_at_12", lv[12], 4);
    chk("level_at_21", lv[21], 7);
    chk("level_sat_24", lv[24], 7);

    // 2: held left gives one request; both cancel
    press(3, 4);
    repeat (4) nstep();
    wait_pulse(40);
    l0 = n_left;
    press(1, 50);
    repeat (15) nstep();
    chk("left_held_once", n_left - l0, 1);
    wait_pulse(40);
    bus.left_i = 1; bus.right_i = 1;
    repeat (2) nstep();
    bus.left_i = 0; bus.right_i = 0;
    wait_pulse(40);
    chk("both_left_o", 32'(bus.left_o), 0);
    chk("both_right_o", 32'(bus.right_o), 0);
    press(0, 2);
    wait_pulse(40);
    chk("right_only_r", 32'(bus.right_o), 1);
    chk("right_only_l", 32'(bus.left_o), 0);

    // 3: busy defers one tick
    press(3, 4);
    repeat (4) nstep();
    wait_pulse(40);
    bus.d_act_i = 0;
    p0 = n_pulse;
    repeat (25) nstep();
    chk("busy_no_pulse", n_pulse - p0, 0);
    bus.d_act_i = 1;
    pat = '0;
    for (int k = 4; k >= 0; k--) begin
      nstep();
      pat[k] = bus.e_act_o;
    end
    chk("deferred_pattern", 32'(pat), 32'(5'b01001));

    // 4: pause at tick 4 and resume
    press(3, 4);
    repeat (4) nstep();
    wait_pulse(40);
    nstep();
    press(2, 3);
    chk("pause_state", 32'(bus.state_o), 2);
    p0 = n_pulse;
    repeat (100) nstep();
    chk("pause_no_pulse", n_pulse - p0, 0);
    chk("pause_state_hold", 32'(bus.state_o), 2);
    t_run = -1;
    t_pulse = -1;
    bus.pause_i = 1;
    for (int i = 1; i <= 30; i++) begin
      nstep();
      if (i == 3) bus.pause_i = 0;
      if (t_run < 0 && bus.state_o == 2'b01) t_run = i;
      if (t_pulse < 0 && bus.e_act_o === 1'b1)
        t_pulse = i;
    end
    chk("resume_latency", t_run, 3);
    chk("resume_to_pulse", t_pulse - t_run, 7);

    // 5: over beats pause, start restarts
    for (int k = 0; k < 4; k++) wait_pulse(40);
    nstep();
    bus.pause_i = 1;
    nstep();
    nstep();
    bus.over_i = 1;
    nstep();
    bus.pause_i = 0;
    nstep();
    nstep();
    bus.over_i = 0;
    chk("over_state", 32'(bus.state_o), 3);
    p0 = n_pulse;
    repeat (30) nstep();
    chk("over_no_pulse", n_pulse - p0, 0);
    chk("over_state_hold", 32'(bus.state_o), 3);
    ar0 = n_ar;
    press(3, 4);
    repeat (4) nstep();
    chk("over_restart_ar", n_ar - ar0, 1);
    chk("over_restart_st", 32'(bus.state_o), 1);
    chk("over_restart_lv", 32'(bus.level_o), 0);

    // 6: asynchronous reset while busy
    wait_pulse(40);
    bus.d_act_i = 0;
    repeat (2) nstep();
    chk("pre_reset_run", 32'(bus.state_o), 1);
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1 chk("async_reset_outs", all_outs(), 0);
    repeat (2) nstep();
    reset_i = 1'b0;
    bus.d_act_i = 1;
    p0 = n_pulse;
    repeat (30) nstep();
    chk("post_reset_quiet", n_pulse - p0, 0);
    chk("post_reset_idle", 32'(bus.state_o), 0);
    press(3, 4);
    repeat (4) nstep();
    chk("post_reset_start", 32'(bus.state_o), 1);
    repeat (20) nstep();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
